// File: rtl/elpis_pkg.sv
// Shared register-file widths and the writeback entry layout.
package elpis_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO holding long-latency results awaiting the write port.
// Latency: pushed entry visible at head_dat the cycle after the push.
// Backpressure: caller must not push when count == DEPTH; push and pop may coincide.
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_vld,
  output logic [WIDTH-1:0] head_dat,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_vld) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + PW'(1);
      if (pop_vld)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_vld, pop_vld})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Arbitrates ALU and long-latency results onto one register-file write port and tracks pending rd.
// Latency: result accepted in cycle N is written (rf_wrd) in cycle N+1; hazard is combinational.
// Backpressure: ALU never stalls; lu_ready falls when the result FIFO is full (registered count).
module writeback_unit #(
  parameter int XLEN     = elpis_pkg::XLEN,
  parameter int LU_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      alu_valid,
  input  logic [4:0]                alu_rd,
  input  logic [XLEN-1:0]           alu_data,
  input  logic                      lu_valid,
  input  logic [4:0]                lu_rd,
  input  logic [XLEN-1:0]           lu_data,
  output logic                      lu_ready,
  input  logic                      iss_valid,
  input  logic [4:0]                iss_rd,
  input  logic [4:0]                chk_rs1,
  input  logic [4:0]                chk_rs2,
  input  logic [4:0]                chk_rd,
  output logic                      hazard,
  output logic                      rf_wrd,
  output logic [4:0]                rf_addr,
  output logic [XLEN-1:0]           rf_data,
  output logic [$clog2(LU_DEPTH):0] lu_count
);
  import elpis_pkg::*;

  localparam int CW = $clog2(LU_DEPTH) + 1;
  localparam logic [CW-1:0] LU_FULL = CW'(LU_DEPTH);

  // Same layout as wb_entry_t, but sized by this instance's XLEN.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } lu_entry_t;

  lu_entry_t   push_dat;
  lu_entry_t   head_dat;
  logic        alu_wr;
  logic        lu_keep;
  logic        fifo_empty;
  logic        pop_vld;
  logic        push_vld;
  logic        bypass;
  logic        rf_from_lu;
  logic [31:0] pending;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;

  assign lu_ready   = (lu_count < LU_FULL);
  assign fifo_empty = (lu_count == '0);
  assign alu_wr     = alu_valid && (alu_rd != 5'd0);
  // rd=0 results still complete the handshake but are never stored.
  assign lu_keep    = lu_valid && lu_ready && (lu_rd != 5'd0);
  assign pop_vld    = !alu_valid && !fifo_empty;
  assign bypass     = !alu_valid && fifo_empty && lu_keep;
  assign push_vld   = lu_keep && !bypass;
  assign push_dat   = '{rd: lu_rd, data: lu_data};

  wb_fifo #(
    .WIDTH($bits(lu_entry_t)),
    .DEPTH(LU_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_vld  (pop_vld),
    .head_dat (head_dat),
    .count    (lu_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_wrd     <= 1'b0;
      rf_addr    <= '0;
      rf_data    <= '0;
      rf_from_lu <= 1'b0;
    end else begin
      rf_wrd     <= alu_wr || pop_vld || bypass;
      rf_from_lu <= pop_vld || bypass;
      if (alu_wr) begin
        rf_addr <= alu_rd;
        rf_data <= alu_data;
      end else if (pop_vld) begin
        rf_addr <= head_dat.rd;
        rf_data <= head_dat.data;
      end else if (bypass) begin
        rf_addr <= lu_rd;
        rf_data <= lu_data;
      end
    end
  end

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (iss_valid) set_mask[iss_rd] = 1'b1;
    if (rf_wrd && rf_from_lu) clr_mask[rf_addr] = 1'b1;
  end

  // A new issue to a register outranks a retiring write to the same register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= ((pending & ~clr_mask) | set_mask) & ~32'd1;
    end
  end

  assign hazard = pending[chk_rs1] | pending[chk_rs2] | pending[chk_rd];

  a_alu_not_pending : assert property (@(posedge clk) disable iff (reset)
    !(alu_valid && pending[alu_rd]));

endmodule

// File: tb/tb_writeback_unit.sv
// Directed vectors, corner sequences and random traffic against a queue-based reference model.
module tb_writeback_unit;
  import elpis_pkg::*;

  localparam int LU_DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        alu_valid, lu_valid, iss_valid;
  logic [4:0]  alu_rd, lu_rd, iss_rd, chk_rs1, chk_rs2, chk_rd;
  logic [31:0] alu_data, lu_data;
  logic        lu_ready, hazard, rf_wrd;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [2:0]  lu_count;

  writeback_unit #(.XLEN(32), .LU_DEPTH(LU_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd), .hazard(hazard),
    .rf_wrd(rf_wrd), .rf_addr(rf_addr), .rf_data(rf_data), .lu_count(lu_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: FIFO as a queue, scoreboard as a bit per register.
  wb_entry_t   m_q[$];
  bit [31:0]   m_pend;
  bit          m_wrd, m_from_lu;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        last_hazard, last_ready;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pend    = '0;
    m_wrd     = 1'b0;
    m_from_lu = 1'b0;
    m_addr    = '0;
    m_data    = '0;
  endtask

  // One clock cycle: drive, check combinational outputs, advance model, check registered outputs.
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                      input logic iv, input logic [4:0] ird,
                      input logic [4:0] c1, input logic [4:0] c2, input logic [4:0] c3);
    bit          acc, nw, nlu;
    logic [4:0]  na;
    logic [31:0] nd;
    wb_entry_t   e;
    alu_valid = av; alu_rd = ard; alu_data = adat;
    lu_valid  = lv; lu_rd  = lrd; lu_data  = ldat;
    iss_valid = iv; iss_rd = ird;
    chk_rs1 = c1; chk_rs2 = c2; chk_rd = c3;
    #1;
    last_hazard = hazard;
    last_ready  = lu_ready;
    check("lu_ready", 32'(lu_ready), 32'(m_q.size() < LU_DEPTH));
    check("hazard", 32'(hazard), 32'(m_pend[c1] | m_pend[c2] | m_pend[c3]));
    acc = lv && (m_q.size() < LU_DEPTH);
    nw = 1'b0; nlu = 1'b0; na = m_addr; nd = m_data;
    if (av) begin
      if (ard != 5'd0) begin nw = 1'b1; na = ard; nd = adat; end
    end else if (m_q.size() != 0) begin
      e = m_q.pop_front();
      nw = 1'b1; nlu = 1'b1; na = e.rd; nd = e.data;
    end else if (acc && lrd != 5'd0) begin
      nw = 1'b1; nlu = 1'b1; na = lrd; nd = ldat; acc = 1'b0;
    end
    if (acc && lrd != 5'd0) begin
      e.rd = lrd; e.data = ldat;
      m_q.push_back(e);
    end
    if (m_wrd && m_from_lu) m_pend[m_addr] = 1'b0;
    if (iv && ird != 5'd0) m_pend[ird] = 1'b1;
    m_wrd = nw; m_from_lu = nlu; m_addr = na; m_data = nd;
    @(posedge clk);
    #1;
    check("rf_wrd", 32'(rf_wrd), 32'(m_wrd));
    check("lu_count", 32'(lu_count), 32'(m_q.size()));
    if (m_wrd) begin
      check("rf_addr", 32'(rf_addr), 32'(m_addr));
      check("rf_data", rf_data, m_data);
    end
  endtask

  task automatic idle(input logic [4:0] c1);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, c1, 5'd0, 5'd0);
  endtask

  typedef struct {
    logic av; logic [4:0] ard; logic [31:0] adat;
    logic lv; logic [4:0] lrd; logic [31:0] ldat;
    logic iv; logic [4:0] ird; logic [4:0] chk;
    logic e_haz; logic e_wrd; logic [4:0] e_addr; logic [31:0] e_data; logic [2:0] e_cnt;
  } vec_t;

  vec_t tv[10];

  initial begin
    // alu -> write next cycle; issue/lu bypass with hazard window; alu+lu collision; rd=0 drops.
    tv[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 3'd0};
    tv[1] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd7, 5'd7, 1'b0, 1'b0, 5'd0, 32'h0,        3'd0};
    tv[2] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd7, 1'b1, 1'b0, 5'd0, 32'h0,        3'd0};
    tv[3] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 5'd7, 1'b1, 1'b1, 5'd7, 32'h11,       3'd0};
    tv[4] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd7, 1'b1, 1'b0, 5'd0, 32'h0,        3'd0};
    tv[5] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd7, 1'b0, 1'b0, 5'd0, 32'h0,        3'd0};
    tv[6] = '{1'b1, 5'd3, 32'h33,       1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd3, 32'h33,       3'd1};
    tv[7] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd4, 32'h44,       3'd0};
    tv[8] = '{1'b1, 5'd0, 32'hAA,       1'b1, 5'd0, 32'hBB, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0,        3'd0};
    tv[9] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0,        3'd0};

    reset = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lu_valid = 1'b0; lu_rd = '0; lu_data = '0;
    iss_valid = 1'b0; iss_rd = '0;
    chk_rs1 = 5'd9; chk_rs2 = 5'd0; chk_rd = 5'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset rf_wrd", 32'(rf_wrd), 32'd0);
    check("reset rf_addr", 32'(rf_addr), 32'd0);
    check("reset rf_data", rf_data, 32'd0);
    check("reset lu_count", 32'(lu_count), 32'd0);
    check("reset lu_ready", 32'(lu_ready), 32'd1);
    check("reset hazard", 32'(hazard), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      step(tv[i].av, tv[i].ard, tv[i].adat, tv[i].lv, tv[i].lrd, tv[i].ldat,
           tv[i].iv, tv[i].ird, tv[i].chk, 5'd0, 5'd0);
      check($sformatf("vec%0d hazard", i), 32'(last_hazard), 32'(tv[i].e_haz));
      check($sformatf("vec%0d rf_wrd", i), 32'(rf_wrd), 32'(tv[i].e_wrd));
      check($sformatf("vec%0d lu_count", i), 32'(lu_count), 32'(tv[i].e_cnt));
      if (tv[i].e_wrd) begin
        check($sformatf("vec%0d rf_addr", i), 32'(rf_addr), 32'(tv[i].e_addr));
        check($sformatf("vec%0d rf_data", i), rf_data, tv[i].e_data);
      end
    end

    // Fill the FIFO behind a busy ALU, then drain in order.
    begin
      logic [4:0] alu_rds [5];
      alu_rds = '{5'd1, 5'd2, 5'd3, 5'd5, 5'd6};
      for (int i = 0; i < 5; i++) begin
        step(1'b1, alu_rds[i], 32'hA000 + i, 1'b1, 5'(10 + i), 32'h100 + i,
             1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        check($sformatf("fill%0d lu_ready", i), 32'(last_ready), 32'(i < 4));
        check($sformatf("fill%0d lu_count", i), 32'(lu_count), (i < 4) ? i + 1 : 4);
      end
      for (int i = 0; i < 4; i++) begin
        idle(5'd0);
        check($sformatf("drain%0d rf_addr", i), 32'(rf_addr), 32'(10 + i));
        check($sformatf("drain%0d rf_data", i), rf_data, 32'h100 + i);
        check($sformatf("drain%0d lu_count", i), 32'(lu_count), 3 - i);
      end
      idle(5'd0);
    end

    // Reset mid-operation with three queued results and x9 pending.
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 5'(1 + i), 32'hB0 + i, 1'b1, 5'(20 + i), 32'hC0 + i,
           1'b0, 5'd0, 5'd9, 5'd0, 5'd0);
    end
    alu_valid = 1'b0; lu_valid = 1'b0; iss_valid = 1'b0; chk_rs1 = 5'd9;
    #1;
    check("pre-reset lu_count", 32'(lu_count), 32'd3);
    check("pre-reset hazard", 32'(hazard), 32'd1);
    check("pre-reset rf_wrd", 32'(rf_wrd), 32'd1);
    reset = 1'b1;
    #1;
    check("mid-reset lu_count", 32'(lu_count), 32'd0);
    check("mid-reset hazard", 32'(hazard), 32'd0);
    check("mid-reset rf_wrd", 32'(rf_wrd), 32'd0);
    check("mid-reset lu_ready", 32'(lu_ready), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      idle(5'd9);
      check($sformatf("post-reset%0d rf_wrd", i), 32'(rf_wrd), 32'd0);
    end

    // Random traffic; ALU never targets a register the model holds pending.
    for (int i = 0; i < 1500; i++) begin
      logic       av, lv, iv;
      logic [4:0] ar, lr, ir;
      av = 1'($urandom_range(0, 1));
      ar = 5'($urandom_range(0, 31));
      if (m_pend[ar]) ar = 5'd0;
      lv = ($urandom_range(0, 9) < 6);
      lr = 5'($urandom_range(0, 15));
      iv = ($urandom_range(0, 9) < 3);
      ir = 5'($urandom_range(0, 15));
      step(av, ar, $urandom, lv, lr, $urandom, iv, ir,
           5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width.
REQ-002 SHALL have parameter LU_DEPTH, default 4, long-latency result FIFO depth (power of two, >=2).
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports alu_valid  input  1, alu_rd  input  5, alu_data  input  XLEN: single-cycle ALU result; no backpressure.
REQ-006 SHALL have ports lu_valid  input  1, lu_rd  input  5, lu_data  input  XLEN: long-latency (load/mul/div) result.
REQ-007 SHALL have port lu_ready  output  1  high when the FIFO can accept a long-latency result.
REQ-008 SHALL have ports iss_valid  input  1, iss_rd  input  5: issue of a long-latency op; marks iss_rd pending.
REQ-009 SHALL have ports chk_rs1, chk_rs2, chk_rd  input  5 each: operands of the instruction in decode.
REQ-010 SHALL have port hazard  output  1  any checked register pending.
REQ-011 SHALL have ports rf_wrd  output  1, rf_addr  output  5, rf_data  output  XLEN: register-file write port.
REQ-012 SHALL have port lu_count  output  $clog2(LU_DEPTH)+1  current FIFO occupancy.

Function
REQ-013 SHALL register rf_wrd/rf_addr/rf_data; a result accepted in cycle N is written in cycle N+1.
REQ-014 SHALL select per cycle: alu_valid first, else FIFO head, else bypassed lu result; at most one write per cycle.
REQ-015 SHALL accept lu result when lu_valid && lu_ready; if FIFO empty and alu_valid low, it bypasses the FIFO and is written next cycle.
REQ-016 SHALL push an accepted lu result into the FIFO when alu_valid is high or FIFO non-empty; FIFO order strictly preserved.
REQ-017 SHALL drive lu_ready = (lu_count < LU_DEPTH), from registered count only; a same-cycle pop does not raise it.
REQ-018 SHALL push and pop in the same cycle when both occur; lu_count unchanged; pointers wrap modulo LU_DEPTH.
REQ-019 SHALL drop results with rd = 0 (ALU or lu): no write, no FIFO entry, lu handshake still completes.
REQ-020 SHALL keep scoreboard pending[31:1]; iss_valid with iss_rd != 0 sets pending[iss_rd] next cycle.
REQ-021 SHALL clear pending[rf_addr] in the cycle a long-latency result is written (rf_wrd from FIFO or bypass path).
REQ-022 SHALL give set priority over clear when both target the same register in one cycle.
REQ-023 SHALL compute hazard combinationally as pending[chk_rs1] | pending[chk_rs2] | pending[chk_rd]; register 0 never pending.
REQ-024 SHALL NOT clear pending on ALU writes; alu_valid with pending alu_rd is an illegal input (assertion).

Reset
REQ-025 SHALL on reset force rf_wrd=0, rf_addr=0, rf_data=0, lu_count=0, FIFO pointers=0, pending all 0, hazard=0, lu_ready=1.
REQ-026 SHALL discard FIFO contents and in-flight writes when reset asserts mid-operation; no write after reset release until a new result arrives.

Structure
REQ-027 SHALL place XLEN default, REG_ADDR_W=5 and the wb_entry_t typedef {rd, data} in shared package elpis_pkg.
REQ-028 SHALL instantiate one sub-module wb_fifo (synchronous, parameterised depth, count output); scoreboard and arbitration stay in writeback_unit.

Verification
REQ-029 SHALL test: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF -> next cycle rf_wrd=1, rf_addr=5, rf_data=0xDEADBEEF.
REQ-030 SHALL test: iss rd=7; later lu rd=7 data=0x11 with alu idle, FIFO empty -> write x7=0x11 next cycle, hazard for chk_rs1=7 high until that cycle, low after.
REQ-031 SHALL test: alu rd=3 and lu rd=4 same cycle -> x3 written at N+1, x4 at N+2, lu_count 1 then 0.
REQ-032 SHALL test: alu_valid held 5 cycles, lu_valid each cycle -> lu_ready low after 4 accepts, lu_count=4; drains in order after alu idles.
REQ-033 SHALL test: lu rd=0 and alu rd=0 -> rf_wrd stays 0, lu_count unchanged.
REQ-034 SHALL test: reset asserted with lu_count=3 and pending[9]=1 -> immediately lu_count=0, hazard=0, rf_wrd=0.
